id_exe_stage: RTL and testbench

- ID/EXE pipeline register of the 5-stage pipeline, directly downstream of the decode control unit.
- Captures decoded control and operand data each cycle.
- Inserts bubbles on stall or flush.
- Resolves EXE-side operand selection (register, shift amount, immediate, forwarded MEM/WB data) from the registered select codes, and drives the EXE-stage feedback signals back to the control unit.

---
 rtl/id_exe_stage.sv | 144 ++++++++++++++
 tb/tb_id_exe_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register: captures decoded control/operands, inserts bubbles on stall/flush,
// and resolves EXE operand forwarding. Optional IDEXE_PERF_CNT_EN adds issue/bubble counters.
module id_exe_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_en,
   input  logic          flush,
   input  logic          id_wreg,
   input  logic          id_m2reg,
   input  logic          id_wmem,
   input  logic          id_wz,
   input  logic [2:0]    id_aluc,
   input  logic [1:0]    id_a_sel,
   input  logic [1:0]    id_b_sel,
   input  logic          id_is_jump,
   input  logic          id_is_beq,
   input  logic          id_is_bne,
   input  logic [DW-1:0] id_ra,
   input  logic [DW-1:0] id_rb,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_sa,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_pc4,
   input  logic [DW-1:0] mem_alu,
   input  logic [DW-1:0] wb_data,
   output logic          exe_wreg,
   output logic          exe_m2reg,
   output logic          exe_wmem,
   output logic          exe_wz,
   output logic [2:0]    exe_aluc,
   output logic          exe_is_jump,
   output logic          exe_is_beq,
   output logic          exe_is_bne,
   output logic [RW-1:0] exe_rd,
   output logic [DW-1:0] exe_pc4,
   output logic [DW-1:0] exe_rb,
   output logic [DW-1:0] exe_a,
   output logic [DW-1:0] exe_b,
`ifdef IDEXE_PERF_CNT_EN
   output logic [31:0]   perf_issued,
   output logic [31:0]   perf_bubbles,
`endif
   output logic          exe_valid
);

   logic [1:0]    a_sel_q, b_sel_q;
   logic [DW-1:0] ra_q, rb_q, imm_q;
   logic [RW-1:0] sa_q;
   logic          bubble;

   // Flush and stall both produce a bubble; flush has priority but the result is identical.
   assign bubble = flush | stall_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         exe_valid   <= 1'b0;
         exe_wreg    <= 1'b0;
         exe_m2reg   <= 1'b0;
         exe_wmem    <= 1'b0;
         exe_wz      <= 1'b0;
         exe_aluc    <= 3'b000;
         exe_is_jump <= 1'b0;
         exe_is_beq  <= 1'b0;
         exe_is_bne  <= 1'b0;
         exe_rd      <= '0;
         exe_pc4     <= '0;
         a_sel_q     <= 2'b00;
         b_sel_q     <= 2'b00;
         ra_q        <= '0;
         rb_q        <= '0;
         imm_q       <= '0;
         sa_q        <= '0;
      end else begin
         exe_valid   <= 1'b1;
         exe_wreg    <= id_wreg;
         exe_m2reg   <= id_m2reg;
         exe_wmem    <= id_wmem;
         exe_wz      <= id_wz;
         exe_aluc    <= id_aluc;
         exe_is_jump <= id_is_jump;
         exe_is_beq  <= id_is_beq;
         exe_is_bne  <= id_is_bne;
         exe_rd      <= id_rd;
         exe_pc4     <= id_pc4;
         a_sel_q     <= id_a_sel;
         b_sel_q     <= id_b_sel;
         ra_q        <= id_ra;
         rb_q        <= id_rb;
         imm_q       <= id_imm;
         sa_q        <= id_sa;
      end
   end

   // Select codes were computed at decode: 10 = producer now in MEM, 11 = producer now in WB.
   always_comb begin
      exe_a = ra_q;
      case (a_sel_q)
         2'b01:   exe_a = {{(DW-RW){1'b0}}, sa_q};
         2'b10:   exe_a = mem_alu;
         2'b11:   exe_a = wb_data;
         default: exe_a = ra_q;
      endcase
   end

   always_comb begin
      exe_b  = rb_q;
      exe_rb = rb_q;
      case (b_sel_q)
         2'b01: begin
            exe_b  = imm_q;
            exe_rb = rb_q;
         end
         2'b10: begin
            exe_b  = mem_alu;
            exe_rb = mem_alu;
         end
         2'b11: begin
            exe_b  = wb_data;
            exe_rb = wb_data;
         end
         default: begin
            exe_b  = rb_q;
            exe_rb = rb_q;
         end
      endcase
   end

`ifdef IDEXE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued  <= '0;
         perf_bubbles <= '0;
      end else if (bubble) begin
         if (perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
      end else begin
         if (perf_issued != 32'hFFFF_FFFF) perf_issued <= perf_issued + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: reset, pass-through, forwarding, shift/imm, stall and flush bubbles.
// Checks perf counters too when IDEXE_PERF_CNT_EN is defined.
module tb_id_exe_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst, stall_en, flush;
   logic          id_wreg, id_m2reg, id_wmem, id_wz;
   logic [2:0]    id_aluc;
   logic [1:0]    id_a_sel, id_b_sel;
   logic          id_is_jump, id_is_beq, id_is_bne;
   logic [DW-1:0] id_ra, id_rb, id_imm, id_pc4, mem_alu, wb_data;
   logic [RW-1:0] id_sa, id_rd;
   logic          exe_wreg, exe_m2reg, exe_wmem, exe_wz;
   logic [2:0]    exe_aluc;
   logic          exe_is_jump, exe_is_beq, exe_is_bne;
   logic [RW-1:0] exe_rd;
   logic [DW-1:0] exe_pc4, exe_rb, exe_a, exe_b;
   logic          exe_valid;
`ifdef IDEXE_PERF_CNT_EN
   logic [31:0]   perf_issued, perf_bubbles;
   int            exp_issued = 0;
   int            exp_bubbles = 0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   id_exe_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .stall_en(stall_en), .flush(flush),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_wz(id_wz),
      .id_aluc(id_aluc), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .id_is_jump(id_is_jump), .id_is_beq(id_is_beq), .id_is_bne(id_is_bne),
      .id_ra(id_ra), .id_rb(id_rb), .id_imm(id_imm), .id_sa(id_sa), .id_rd(id_rd),
      .id_pc4(id_pc4), .mem_alu(mem_alu), .wb_data(wb_data),
      .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_wz(exe_wz),
      .exe_aluc(exe_aluc), .exe_is_jump(exe_is_jump), .exe_is_beq(exe_is_beq),
      .exe_is_bne(exe_is_bne), .exe_rd(exe_rd), .exe_pc4(exe_pc4), .exe_rb(exe_rb),
      .exe_a(exe_a), .exe_b(exe_b),
`ifdef IDEXE_PERF_CNT_EN
      .perf_issued(perf_issued), .perf_bubbles(perf_bubbles),
`endif
      .exe_valid(exe_valid)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, sample 1 time unit later.
   task automatic step();
`ifdef IDEXE_PERF_CNT_EN
      if (!rst) begin
         if (flush || stall_en) exp_bubbles++;
         else exp_issued++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_wz = 0; id_aluc = 3'b000;
      id_a_sel = 2'b00; id_b_sel = 2'b00; id_is_jump = 0; id_is_beq = 0; id_is_bne = 0;
      id_ra = '0; id_rb = '0; id_imm = '0; id_sa = '0; id_rd = '0; id_pc4 = '0;
   endtask

   initial begin
      rst = 1; stall_en = 0; flush = 0; mem_alu = '0; wb_data = '0;
      clear_id();
      step(); step();
      rst = 0;
      check("post_reset_valid", {31'b0, exe_valid}, 32'h0);

      // Load a fully nonzero instruction, then reset asynchronously between edges.
      id_wreg = 1; id_m2reg = 1; id_wmem = 1; id_wz = 1; id_aluc = 3'b101;
      id_is_jump = 1; id_is_beq = 1; id_is_bne = 1; id_ra = 32'hA5; id_rb = 32'h5A;
      id_imm = 32'h77; id_sa = 5'd3; id_rd = 5'd9; id_pc4 = 32'h100;
      step();
      check("load_valid", {31'b0, exe_valid}, 32'h1);
      check("load_aluc", {29'b0, exe_aluc}, 32'h5);
      check("load_rd", {27'b0, exe_rd}, 32'h9);
      check("load_pc4", exe_pc4, 32'h100);
      check("load_a", exe_a, 32'hA5);
      #2 rst = 1;
      #1;
      check("arst_valid", {31'b0, exe_valid}, 32'h0);
      check("arst_ctl", {27'b0, exe_wreg, exe_m2reg, exe_wmem, exe_wz, exe_is_beq}, 32'h0);
      check("arst_aluc", {29'b0, exe_aluc}, 32'h0);
      check("arst_rd", {27'b0, exe_rd}, 32'h0);
      check("arst_pc4", exe_pc4, 32'h0);
      check("arst_a", exe_a, 32'h0);
      check("arst_b", exe_b, 32'h0);
`ifdef IDEXE_PERF_CNT_EN
      exp_issued = 0; exp_bubbles = 0;
`endif
      rst = 0;
      #1;
      check("release_valid", {31'b0, exe_valid}, 32'h0);

      // Pass-through
      clear_id();
      id_wreg = 1; id_aluc = 3'b001; id_ra = 32'h11; id_rb = 32'h22; id_rd = 5'd7;
      step();
      check("pt_a", exe_a, 32'h11);
      check("pt_b", exe_b, 32'h22);
      check("pt_rb", exe_rb, 32'h22);
      check("pt_rd", {27'b0, exe_rd}, 32'h7);
      check("pt_valid_wreg", {30'b0, exe_valid, exe_wreg}, 32'h3);
      check("pt_aluc", {29'b0, exe_aluc}, 32'h1);

      // Forwarding from MEM / WB
      id_a_sel = 2'b10; id_b_sel = 2'b11; mem_alu = 32'h1234; wb_data = 32'hBEEF;
      step();
      check("fwd_a", exe_a, 32'h1234);
      check("fwd_b", exe_b, 32'hBEEF);
      check("fwd_rb", exe_rb, 32'hBEEF);
      mem_alu = 32'h5;
      #1;
      check("fwd_a_comb", exe_a, 32'h5);

      // Shift amount / immediate
      id_a_sel = 2'b01; id_sa = 5'd5; id_b_sel = 2'b01; id_imm = 32'hFFFF_FFFC; id_rb = 32'h9;
      step();
      check("sh_a", exe_a, 32'h5);
      check("imm_b", exe_b, 32'hFFFF_FFFC);
      check("imm_rb", exe_rb, 32'h9);

      // Store data forwarded from MEM
      id_a_sel = 2'b00; id_b_sel = 2'b10; mem_alu = 32'hCAFE;
      step();
      check("st_fwd_rb", exe_rb, 32'hCAFE);
      check("st_fwd_b", exe_b, 32'hCAFE);

      // Stall bubble, then release
      clear_id();
      id_is_beq = 1; id_wreg = 1; id_rb = 32'h44; id_rd = 5'd3; stall_en = 1;
      step();
      check("stall_beq", {31'b0, exe_is_beq}, 32'h0);
      check("stall_wreg", {31'b0, exe_wreg}, 32'h0);
      check("stall_valid", {31'b0, exe_valid}, 32'h0);
      check("stall_b", exe_b, 32'h0);
      check("stall_rd", {27'b0, exe_rd}, 32'h0);
      stall_en = 0;
      step();
      check("unstall_beq", {31'b0, exe_is_beq}, 32'h1);
      check("unstall_valid", {31'b0, exe_valid}, 32'h1);
      check("unstall_b", exe_b, 32'h44);

      // Flush together with stall
      clear_id();
      id_wmem = 1; id_is_bne = 1; flush = 1; stall_en = 1;
      step();
      check("flush_wmem", {31'b0, exe_wmem}, 32'h0);
      check("flush_valid", {31'b0, exe_valid}, 32'h0);
      check("flush_bne", {31'b0, exe_is_bne}, 32'h0);
`ifdef IDEXE_PERF_CNT_EN
      check("perf_bubbles", perf_bubbles, exp_bubbles[31:0]);
      check("perf_issued", perf_issued, exp_issued[31:0]);
`endif
      flush = 0; stall_en = 0;
      step();
      check("post_flush_wmem", {31'b0, exe_wmem}, 32'h1);
      check("post_flush_valid", {31'b0, exe_valid}, 32'h1);
`ifdef IDEXE_PERF_CNT_EN
      check("perf_issued_end", perf_issued, exp_issued[31:0]);
      check("perf_bubbles_end", perf_bubbles, exp_bubbles[31:0]);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
